nn_layer_sched: RTL and testbench

NN_LAYER_SCHED -- requirements
Module: nn_layer_sched

---
 rtl/nn_layer_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_nn_layer_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sched.sv
// nn_layer_sched: sequencer for a two-layer neural-network inference.
// It streams the input vector through the hidden neuron array, streams the
// hidden outputs through the output neuron array, then optionally scans
// the output neurons for the winning class.
//
// Optional feature macro: NN_SCHED_ARGMAX_EN
//   defined   -> ARGMAX scan drives out_sel and produces class_idx
//   undefined -> WAIT_HO goes straight to DONE; out_sel and class_idx are 0
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   go                       start request, sampled in IDLE only
//   busy, done               activity flag, one-cycle completion pulse
//   addr_in, addr_ih         input-pixel / hidden-weight address (LOAD_IH)
//   addr_ho, hid_sel         output-weight address / hidden mux select (LOAD_HO)
//   start_ih, start_ho       one-cycle clear pulse to each neuron array
//   mac_en_ih, mac_en_ho     accumulate strobes, one cycle behind the address
//   ready_ih_all/_ho_all     AND of the neuron-array ready flags
//   out_sel, out_data        output-neuron mux select / selected signed value
//   class_idx                winning class index
module nn_layer_sched #(
    parameter int unsigned N_IN   = 784,
    parameter int unsigned N_HID  = 128,
    parameter int unsigned N_OUT  = 10,
    parameter int unsigned ADDR_W = 17
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W-1:0]          addr_in,
    output logic [ADDR_W-1:0]          addr_ih,
    output logic [ADDR_W-1:0]          addr_ho,
    output logic                       start_ih,
    output logic                       start_ho,
    output logic                       mac_en_ih,
    output logic                       mac_en_ho,
    output logic [$clog2(N_HID)-1:0]   hid_sel,
    input  logic                       ready_ih_all,
    input  logic                       ready_ho_all,
    output logic [3:0]                 out_sel,
    input  logic signed [15:0]         out_data,
    output logic [3:0]                 class_idx
);

    localparam int unsigned HID_W  = $clog2(N_HID);
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] IN_LAST  = ADDR_W'(N_IN - 1);
    localparam logic [ADDR_W-1:0] HID_LAST = ADDR_W'(N_HID - 1);

`ifdef NN_SCHED_ARGMAX_EN
    localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(N_OUT - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_IH, WAIT_IH, LOAD_HO, WAIT_HO, ARGMAX, DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, LOAD_IH, WAIT_IH, LOAD_HO, WAIT_HO, DONE
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    logic                busy_d, done_d;
    logic                start_ih_d, start_ho_d;
    logic                mac_en_ih_d, mac_en_ho_d;
    logic [ADDR_W-1:0]   addr_i_d, addr_ho_d;
    logic [HID_W-1:0]    hid_sel_d;

`ifdef NN_SCHED_ARGMAX_EN
    logic signed [DATA_W-1:0] best_val_q, best_val_d;
    logic [SEL_W-1:0]         best_idx_q, best_idx_d;
    logic [SEL_W-1:0]         out_sel_d, class_idx_d;
    logic                     take_c;
    logic signed [DATA_W-1:0] win_val_c;
    logic [SEL_W-1:0]         win_idx_c;
`endif

    // Next state, shared stage counter and next values of all registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef NN_SCHED_ARGMAX_EN
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        class_idx_d = class_idx;
        // First element seeds the running max; strict '>' keeps the lower index on ties.
        take_c    = (cnt_q == '0) || (out_data > best_val_q);
        win_val_c = take_c ? out_data : best_val_q;
        win_idx_c = take_c ? SEL_W'(cnt_q) : best_idx_q;
`endif

        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = LOAD_IH;
                    cnt_d   = '0;
                end
            end
            LOAD_IH: begin
                if (cnt_q == IN_LAST) begin
                    state_d = WAIT_IH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            // Leave only after the trailing accumulate strobe has gone out.
            WAIT_IH: begin
                if (ready_ih_all && !mac_en_ih) begin
                    state_d = LOAD_HO;
                    cnt_d   = '0;
                end
            end
            LOAD_HO: begin
                if (cnt_q == HID_LAST) begin
                    state_d = WAIT_HO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            WAIT_HO: begin
                if (ready_ho_all && !mac_en_ho) begin
`ifdef NN_SCHED_ARGMAX_EN
                    state_d = ARGMAX;
`else
                    state_d = DONE;
`endif
                    cnt_d   = '0;
                end
            end
`ifdef NN_SCHED_ARGMAX_EN
            ARGMAX: begin
                best_val_d = win_val_c;
                best_idx_d = win_idx_c;
                if (cnt_q == OUT_LAST) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    class_idx_d = win_idx_c;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered, so they are decoded from the upcoming state.
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        start_ih_d  = (state_d == LOAD_IH) && (state_q != LOAD_IH);
        start_ho_d  = (state_d == LOAD_HO) && (state_q != LOAD_HO);
        addr_i_d    = (state_d == LOAD_IH) ? cnt_d : '0;
        addr_ho_d   = (state_d == LOAD_HO) ? cnt_d : '0;
        hid_sel_d   = (state_d == LOAD_HO) ? HID_W'(cnt_d) : '0;
        // Strobes trail the address by the one-cycle memory read latency.
        mac_en_ih_d = (state_q == LOAD_IH);
        mac_en_ho_d = (state_q == LOAD_HO);
`ifdef NN_SCHED_ARGMAX_EN
        out_sel_d   = (state_d == ARGMAX) ? SEL_W'(cnt_d) : '0;
`endif
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            start_ih  <= 1'b0;
            start_ho  <= 1'b0;
            mac_en_ih <= 1'b0;
            mac_en_ho <= 1'b0;
            addr_in   <= '0;
            addr_ih   <= '0;
            addr_ho   <= '0;
            hid_sel   <= '0;
`ifdef NN_SCHED_ARGMAX_EN
            best_val_q <= '0;
            best_idx_q <= '0;
            out_sel    <= '0;
            class_idx  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            start_ih  <= start_ih_d;
            start_ho  <= start_ho_d;
            mac_en_ih <= mac_en_ih_d;
            mac_en_ho <= mac_en_ho_d;
            addr_in   <= addr_i_d;
            addr_ih   <= addr_i_d;
            addr_ho   <= addr_ho_d;
            hid_sel   <= hid_sel_d;
`ifdef NN_SCHED_ARGMAX_EN
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            out_sel    <= out_sel_d;
            class_idx  <= class_idx_d;
`endif
        end
    end

`ifndef NN_SCHED_ARGMAX_EN
    // Without the scan the output-neuron interface is inert.
    logic unused_c;
    assign unused_c  = ^{out_data, SEL_W'(N_OUT)};
    assign out_sel   = '0;
    assign class_idx = '0;
`endif

endmodule

// File: tb/tb_nn_layer_sched.sv
// tb_nn_layer_sched: per-scenario stimulus tables (directed and random),
// an event-schedule reference model and a per-cycle output compare.
module tb_nn_layer_sched;

    localparam int N_IN   = 4;
    localparam int N_HID  = 3;
    localparam int N_OUT  = 10;
    localparam int ADDR_W = 8;
    localparam int HID_W  = 2;
    localparam int L      = 100;
    localparam int NSCEN  = 10;
    localparam int BIG    = 100000;
`ifdef NN_SCHED_ARGMAX_EN
    localparam bit ARG = 1'b1;
`else
    localparam bit ARG = 1'b0;
`endif
    // go at cycle 1: LOAD_IH 2..5, WAIT_IH 6..7, LOAD_HO 8..10, WAIT_HO 11..12
    localparam int DONE_CYC = ARG ? 23 : 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst, go, busy, done;
    logic [ADDR_W-1:0]        addr_in, addr_ih, addr_ho;
    logic                     start_ih, start_ho, mac_en_ih, mac_en_ho;
    logic [HID_W-1:0]         hid_sel;
    logic                     ready_ih_all, ready_ho_all;
    logic [3:0]               out_sel, class_idx;
    logic signed [15:0]       out_data;
    logic signed [15:0]       out_vals [0:15];

    always_comb out_data = out_vals[out_sel];

    nn_layer_sched #(
        .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
        .addr_in(addr_in), .addr_ih(addr_ih), .addr_ho(addr_ho),
        .start_ih(start_ih), .start_ho(start_ho),
        .mac_en_ih(mac_en_ih), .mac_en_ho(mac_en_ho), .hid_sel(hid_sel),
        .ready_ih_all(ready_ih_all), .ready_ho_all(ready_ho_all),
        .out_sel(out_sel), .out_data(out_data), .class_idx(class_idx)
    );

    // Stimulus per cycle
    bit go_a [0:L];
    bit rst_a [0:L];
    bit rih_a [0:L];
    bit rho_a [0:L];
    // Expected and sampled outputs per cycle
    int e_busy [0:L], e_done [0:L], e_ai [0:L], e_aho [0:L], e_sih [0:L], e_sho [0:L];
    int e_mih [0:L], e_mho [0:L], e_hid [0:L], e_osel [0:L], e_cls [0:L], cls_set [0:L];
    int a_busy [0:L], a_done [0:L], a_ain [0:L], a_aih [0:L], a_aho [0:L], a_sih [0:L], a_sho [0:L];
    int a_mih [0:L], a_mho [0:L], a_hid [0:L], a_osel [0:L], a_cls [0:L];

    int n_total = 0;
    int n_pass  = 0;
    int scen;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s (scenario %0d): got %0d, expected %0d", name, scen, act, exp);
    endtask

    function automatic int find_ready(input bit hid_stage, input int from);
        for (int c = from; c < L; c++) begin
            if (hid_stage ? rih_a[c] : rho_a[c]) return c;
        end
        return BIG;
    endfunction

    // Index of the largest signed output; earlier index wins ties.
    function automatic int winner();
        int best = 0;
        for (int j = 1; j < N_OUT; j++) begin
            if (out_vals[j] > out_vals[best]) best = j;
        end
        return best;
    endfunction

    // Schedule each accepted inference from the stimulus tables and paint the expected trace.
    task automatic build_model();
        int t, g, s1, w1, e1, s2, w2, e2, a, d, r, last, cur;
        for (int c = 0; c <= L; c++) begin
            e_busy[c] = 0; e_done[c] = 0; e_ai[c] = 0; e_aho[c] = 0; e_sih[c] = 0; e_sho[c] = 0;
            e_mih[c] = 0; e_mho[c] = 0; e_hid[c] = 0; e_osel[c] = 0; cls_set[c] = -1;
        end
        t = 0;
        while (t < L) begin
            if (rst_a[t]) begin
                cls_set[t+1] = 0;
                t++;
            end else if (!go_a[t]) begin
                t++;
            end else begin
                g  = t;
                s1 = g + 1;                    // first LOAD_IH cycle
                w1 = s1 + N_IN;                // first WAIT_IH cycle (last mac_en_ih)
                e1 = find_ready(1'b1, w1 + 1); // exit needs ready after the final strobe
                s2 = e1 + 1;
                w2 = s2 + N_HID;
                e2 = find_ready(1'b0, w2 + 1);
                a  = e2 + 1;
                d  = ARG ? a + N_OUT : e2 + 1;
                r  = BIG;
                for (int c = g + 1; c <= d && c < L; c++) begin
                    if (rst_a[c] && r == BIG) r = c;
                end
                last = d;
                if (r < last) last = r;
                if (L < last) last = L;
                for (int c = s1; c <= last; c++) begin
                    e_busy[c] = 1;
                    if (c < w1) begin e_ai[c] = c - s1; e_sih[c] = int'(c == s1); end
                    if (c > s1 && c <= w1) e_mih[c] = 1;
                    if (c >= s2 && c < w2) begin
                        e_aho[c] = c - s2; e_hid[c] = c - s2; e_sho[c] = int'(c == s2);
                    end
                    if (c > s2 && c <= w2) e_mho[c] = 1;
                    if (ARG && c >= a && c < d) e_osel[c] = c - a;
                    if (c == d) e_done[c] = 1;
                end
                if (r != BIG) begin
                    cls_set[r+1] = 0;
                    t = r + 1;
                end else begin
                    if (ARG && d <= L) cls_set[d] = winner();
                    t = d + 1;
                end
            end
        end
        cur = 0;
        for (int c = 0; c <= L; c++) begin
            if (cls_set[c] >= 0) cur = cls_set[c];
            e_cls[c] = cur;
        end
    endtask

    task automatic compare_cycle(input int c);
        bit ok;
        ok = (a_busy[c] == e_busy[c]) && (a_done[c] == e_done[c]) && (a_ain[c] == e_ai[c]) &&
             (a_aih[c] == e_ai[c]) && (a_aho[c] == e_aho[c]) && (a_sih[c] == e_sih[c]) &&
             (a_sho[c] == e_sho[c]) && (a_mih[c] == e_mih[c]) && (a_mho[c] == e_mho[c]) &&
             (a_hid[c] == e_hid[c]) && (a_osel[c] == e_osel[c]) && (a_cls[c] == e_cls[c]);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL trace scen=%0d cyc=%0d got busy%0d done%0d ain%0d aih%0d aho%0d sih%0d sho%0d mih%0d mho%0d hid%0d osel%0d cls%0d expected busy%0d done%0d ai%0d aho%0d sih%0d sho%0d mih%0d mho%0d hid%0d osel%0d cls%0d",
                      scen, c, a_busy[c], a_done[c], a_ain[c], a_aih[c], a_aho[c], a_sih[c], a_sho[c],
                      a_mih[c], a_mho[c], a_hid[c], a_osel[c], a_cls[c], e_busy[c], e_done[c], e_ai[c],
                      e_aho[c], e_sih[c], e_sho[c], e_mih[c], e_mho[c], e_hid[c], e_osel[c], e_cls[c]);
    endtask

    task automatic setup(input int s);
        for (int t = 0; t <= L; t++) begin
            go_a[t] = 1'b0; rst_a[t] = 1'b0; rih_a[t] = 1'b1; rho_a[t] = 1'b1;
        end
        for (int j = 0; j < 16; j++) out_vals[j] = 16'sd0;
        rst_a[0] = 1'b1;
        case (s)
            0: begin
                go_a[1] = 1'b1;
                out_vals[0] = -16'sd5; out_vals[1] = 16'sd3; out_vals[2] = 16'sd9; out_vals[3] = 16'sd9;
            end
            1: begin
                go_a[1] = 1'b1;
                for (int t = 0; t <= L; t++) rih_a[t] = (t >= 22);
                for (int j = 0; j < N_OUT; j++) out_vals[j] = 16'($urandom);
            end
            2: begin
                go_a[1] = 1'b1;
                out_vals[0] = -16'sd9;  out_vals[1] = -16'sd3;    out_vals[2] = -16'sd100;
                out_vals[3] = -16'sd32768; out_vals[4] = -16'sd2; out_vals[5] = -16'sd50;
                out_vals[6] = -16'sd7;  out_vals[7] = -16'sd1;    out_vals[8] = -16'sd1;
                out_vals[9] = -16'sd20;
            end
            3: begin
                go_a[1] = 1'b1; rst_a[9] = 1'b1; go_a[12] = 1'b1;
            end
            4: begin
                go_a[1] = 1'b1; go_a[4] = 1'b1; go_a[7] = 1'b1; go_a[10] = 1'b1; go_a[13] = 1'b1;
            end
            default: begin
                for (int t = 1; t <= L; t++) begin
                    go_a[t]  = ($urandom_range(0, 3) == 0);
                    rst_a[t] = ($urandom_range(0, 59) == 0);
                    rih_a[t] = $urandom_range(0, 1) == 1;
                    rho_a[t] = $urandom_range(0, 1) == 1;
                end
                for (int j = 0; j < N_OUT; j++) begin
                    if (s % 2 == 1) out_vals[j] = 16'($urandom_range(0, 6)) - 16'd3;
                    else            out_vals[j] = 16'($urandom);
                end
            end
        endcase
    endtask

    task automatic run_scenario();
        for (int t = 0; t < L; t++) begin
            rst = rst_a[t]; go = go_a[t]; ready_ih_all = rih_a[t]; ready_ho_all = rho_a[t];
            @(posedge clk);
            #1;
            a_busy[t+1] = int'(busy);     a_done[t+1] = int'(done);
            a_ain[t+1]  = int'(addr_in);  a_aih[t+1]  = int'(addr_ih);  a_aho[t+1] = int'(addr_ho);
            a_sih[t+1]  = int'(start_ih); a_sho[t+1]  = int'(start_ho);
            a_mih[t+1]  = int'(mac_en_ih); a_mho[t+1] = int'(mac_en_ho);
            a_hid[t+1]  = int'(hid_sel);  a_osel[t+1] = int'(out_sel);  a_cls[t+1] = int'(class_idx);
            compare_cycle(t + 1);
        end
    endtask

    function automatic int done_count();
        int n = 0;
        for (int c = 1; c <= L; c++) n += a_done[c];
        return n;
    endfunction

    initial begin
        int nsho;
        rst = 1'b1; go = 1'b0; ready_ih_all = 1'b0; ready_ho_all = 1'b0;
        for (int j = 0; j < 16; j++) out_vals[j] = 16'sd0;
        @(posedge clk);
        #1;
        for (int s = 0; s < NSCEN; s++) begin
            scen = s;
            setup(s);
            build_model();
            run_scenario();
            case (s)
                0: begin
                    chk("reset_busy", a_busy[1], 0);
                    chk("reset_class", a_cls[1], 0);
                    chk("start_ih_c2", a_sih[2], 1);
                    for (int k = 0; k < N_IN; k++) chk("addr_ih_seq", a_aih[2+k], k);
                    chk("mac_en_ih_c2", a_mih[2], 0);
                    chk("mac_en_ih_c3", a_mih[3], 1);
                    chk("mac_en_ih_c6", a_mih[6], 1);
                    chk("mac_en_ih_c7", a_mih[7], 0);
                    chk("start_ho_c8", a_sho[8], 1);
                    chk("done_once", done_count(), 1);
                    chk("class_tie", a_cls[DONE_CYC], ARG ? 2 : 0);
                end
                1: begin
                    nsho = 0;
                    for (int c = 1; c <= 22; c++) nsho += a_sho[c];
                    chk("wait_ih_busy", a_busy[21], 1);
                    chk("wait_ih_no_start_ho", nsho, 0);
                    chk("wait_ih_start_ho_c23", a_sho[23], 1);
                end
                2: chk("class_negative", a_cls[DONE_CYC], ARG ? 7 : 0);
                3: begin
                    chk("mid_ho_addr_c9", a_aho[9], 1);
                    chk("post_rst_busy", a_busy[10], 0);
                    chk("post_rst_addr_ho", a_aho[10], 0);
                    chk("post_rst_mac_ho", a_mho[10], 0);
                    chk("rerun_done", a_done[ARG ? 34 : 24], 1);
                    chk("rerun_done_once", done_count(), 1);
                end
                4: begin
                    chk("go_busy_done_once", done_count(), 1);
                    chk("go_busy_done_cyc", a_done[DONE_CYC], 1);
                    chk("go_busy_class", a_cls[DONE_CYC], 0);
                end
                default: ;
            endcase
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
